vls_multich: RTL and testbench

- Parametrised successor to the fixed two-port (a/b) vector load/store unit.
- Serves NUM_CH independent channels. Each channel accepts one vector load or store command and expands it into VLEN element requests to the scratchpad, using row (unit) or column (COL_STRIDE) addressing.
- Load elements are gathered into a per-channel buffer and returned to the vector register file with a valid/ready writeback.
- Sits between the vector issue stage and the scratchpad banks.

---
 rtl/vls_multich.sv | 167 ++++++++++++++++
 tb/tb_vls_multich.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vls_multich.sv
// vls_multich: multi-channel vector load/store unit between the vector issue
// stage and the scratchpad banks. Each channel expands one vector command into
// VLEN element requests (row or column addressing). Load responses are
// gathered into a per-channel buffer and written back with valid/ready.
// Optional feature: define VLS_PERF_CNT_EN to add the per-channel saturating
// stall counters on the perf_stall output.
module vls_multich #(
  parameter int NUM_CH     = 2,
  parameter int DW         = 16,
  parameter int AW         = 16,
  parameter int VLEN       = 32,
  parameter int COL_STRIDE = 32,
  parameter int MAX_OUTST  = 4
) (
  input  logic                        CLK,
  input  logic                        nRST,
`ifdef VLS_PERF_CNT_EN
  output logic [NUM_CH*32-1:0]        perf_stall,
`endif
  input  logic [NUM_CH-1:0]           cmd_valid,
  output logic [NUM_CH-1:0]           cmd_ready,
  input  logic [NUM_CH-1:0]           cmd_store,
  input  logic [NUM_CH-1:0]           cmd_col,
  input  logic [NUM_CH*AW-1:0]        cmd_base,
  input  logic [NUM_CH*8-1:0]         cmd_imm,
  input  logic [NUM_CH*4-1:0]         cmd_vd,
  input  logic [NUM_CH*VLEN*DW-1:0]   cmd_sdata,
  output logic [NUM_CH-1:0]           sp_req_valid,
  input  logic [NUM_CH-1:0]           sp_req_ready,
  output logic [NUM_CH-1:0]           sp_wen,
  output logic [NUM_CH*AW-1:0]        sp_addr,
  output logic [NUM_CH*DW-1:0]        sp_wdata,
  input  logic [NUM_CH-1:0]           sp_rvalid,
  input  logic [NUM_CH*DW-1:0]        sp_rdata,
  output logic [NUM_CH-1:0]           wb_valid,
  input  logic [NUM_CH-1:0]           wb_ready,
  output logic [NUM_CH*4-1:0]         wb_vd,
  output logic [NUM_CH*VLEN*DW-1:0]   wb_data,
  output logic [NUM_CH-1:0]           st_done
);

  localparam int IW = $clog2(VLEN);
  localparam int CW = IW + 1;
  localparam int VW = VLEN * DW;
  localparam logic [CW-1:0] VLEN_C = CW'(VLEN);
  localparam logic [CW-1:0] LAST_C = CW'(VLEN - 1);
  localparam logic [3:0]    MAXO_C = 4'(MAX_OUTST);
  localparam logic [AW-1:0] COL_C  = AW'(COL_STRIDE);

  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t               state_q, state_d;
    logic [CW-1:0]        iss_q, rcv_q;
    logic [3:0]           outst_q;
    logic                 store_q, col_q, st_done_q;
    logic [3:0]           vd_q;
    logic [AW-1:0]        eff_q, eff_d, stride, req_addr;
    logic [VW-1:0]        sdata_q, buf_q;
    logic signed [7:0]    imm_s;
    logic [IW-1:0]        iss_idx, rcv_idx;
    logic                 req_v, accept, resp;

    // Effective base address: base plus sign-extended immediate, wrapping at AW bits
    assign imm_s    = cmd_imm[c*8 +: 8];
    assign eff_d    = cmd_base[c*AW +: AW] + AW'(imm_s);
    assign stride   = col_q ? COL_C : AW'(1);
    assign req_addr = eff_q + AW'(iss_q) * stride;
    assign iss_idx  = iss_q[IW-1:0];
    assign rcv_idx  = rcv_q[IW-1:0];

    // Issue and response qualification; loads stop issuing at the outstanding limit
    always_comb begin
      req_v  = (state_q == RUN) && (iss_q < VLEN_C) && (store_q || (outst_q < MAXO_C));
      accept = req_v && sp_req_ready[c];
      resp   = (state_q == RUN) && !store_q && sp_rvalid[c] && (rcv_q < VLEN_C);
    end

    // Next state: stores finish on the last accept, loads on the last response
    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE: if (cmd_valid[c]) state_d = RUN;
        RUN: begin
          if (store_q && accept && (iss_q == LAST_C)) state_d = IDLE;
          if (resp && (rcv_q == LAST_C)) state_d = WB;
        end
        WB:   if (wb_ready[c]) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Channel state, counters, command latch and gather buffer
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        state_q   <= IDLE;
        iss_q     <= '0;
        rcv_q     <= '0;
        outst_q   <= '0;
        store_q   <= 1'b0;
        col_q     <= 1'b0;
        vd_q      <= '0;
        eff_q     <= '0;
        sdata_q   <= '0;
        buf_q     <= '0;
        st_done_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        st_done_q <= 1'b0;
        case (state_q)
          IDLE: begin
            if (cmd_valid[c]) begin
              store_q <= cmd_store[c];
              col_q   <= cmd_col[c];
              vd_q    <= cmd_vd[c*4 +: 4];
              eff_q   <= eff_d;
              sdata_q <= cmd_sdata[c*VW +: VW];
              iss_q   <= '0;
              rcv_q   <= '0;
              outst_q <= '0;
            end
          end
          RUN: begin
            if (accept) iss_q <= iss_q + CW'(1);
            if (accept && !store_q && !resp) begin
              outst_q <= outst_q + 4'd1;
            end else if (resp && !(accept && !store_q) && (outst_q != 4'd0)) begin
              outst_q <= outst_q - 4'd1;
            end
            if (resp) begin
              buf_q[rcv_idx*DW +: DW] <= sp_rdata[c*DW +: DW];
              rcv_q <= rcv_q + CW'(1);
            end
            if (store_q && accept && (iss_q == LAST_C)) st_done_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end

`ifdef VLS_PERF_CNT_EN
    logic        stall;
    logic [31:0] perf_q;
    assign stall = (state_q == RUN) &&
                   ((req_v && !sp_req_ready[c]) ||
                    (!store_q && (iss_q < VLEN_C) && (outst_q == MAXO_C)));

    // Saturating count of issue-stalled cycles, cleared only by reset
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) perf_q <= '0;
      else if (stall && (perf_q != 32'hFFFF_FFFF)) perf_q <= perf_q + 32'd1;
    end
    assign perf_stall[c*32 +: 32] = perf_q;
`endif

    assign cmd_ready[c]          = (state_q == IDLE);
    assign sp_req_valid[c]       = req_v;
    assign sp_wen[c]             = req_v && store_q;
    assign sp_addr[c*AW +: AW]   = req_v ? req_addr : '0;
    assign sp_wdata[c*DW +: DW]  = (req_v && store_q) ? sdata_q[iss_idx*DW +: DW] : '0;
    assign wb_valid[c]           = (state_q == WB);
    assign wb_vd[c*4 +: 4]       = (state_q == WB) ? vd_q : '0;
    assign wb_data[c*VW +: VW]   = (state_q == WB) ? buf_q : '0;
    assign st_done[c]            = st_done_q;
  end

endmodule

// File: tb/tb_vls_multich.sv
// tb_vls_multich: scoreboard bench for vls_multich. Stimulus pushes expected
// requests/writebacks; a negedge monitor pops and compares them, and a
// scratchpad model returns load data in request order.
module tb_vls_multich;
  localparam int NCH  = 2;
  localparam int DW   = 16;
  localparam int AW   = 16;
  localparam int VLEN = 32;
  localparam int CS   = 32;
  localparam int MAXO = 4;
  localparam int VW   = VLEN * DW;

  logic                 CLK, nRST;
  logic [NCH-1:0]       cmd_valid, cmd_ready, cmd_store, cmd_col;
  logic [NCH*AW-1:0]    cmd_base;
  logic [NCH*8-1:0]     cmd_imm;
  logic [NCH*4-1:0]     cmd_vd;
  logic [NCH*VW-1:0]    cmd_sdata;
  logic [NCH-1:0]       sp_req_valid, sp_req_ready, sp_wen, sp_rvalid;
  logic [NCH*AW-1:0]    sp_addr;
  logic [NCH*DW-1:0]    sp_wdata, sp_rdata;
  logic [NCH-1:0]       wb_valid, wb_ready, st_done;
  logic [NCH*4-1:0]     wb_vd;
  logic [NCH*VW-1:0]    wb_data;
`ifdef VLS_PERF_CNT_EN
  logic [NCH*32-1:0]    perf_stall;
  logic [31:0]          p0;
`endif

  typedef struct { logic wen; logic [AW-1:0] addr; logic [DW-1:0] wdata; bit last; } req_t;
  typedef struct { logic [3:0] vd; logic [VW-1:0] data; } wb_t;

  req_t          exp_req[NCH][$];
  wb_t           exp_wb[NCH][$];
  logic [AW-1:0] pend[NCH][$];
  int            st_pend[NCH], acc_cnt[NCH], outst_m[NCH], last_st_acc[NCH];
  bit            hold[NCH];
  bit            stall_prev[NCH];
  logic [AW-1:0] stall_addr[NCH];
  logic [VW-1:0] last_wb_exp[NCH];
  int            cyc, max_outst, n_checks, n_bad;
  int            lat, lat0, a0;

  vls_multich #(.NUM_CH(NCH), .DW(DW), .AW(AW), .VLEN(VLEN),
                .COL_STRIDE(CS), .MAX_OUTST(MAXO)) dut (
`ifdef VLS_PERF_CNT_EN
    .perf_stall(perf_stall),
`endif
    .CLK(CLK), .nRST(nRST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
    .cmd_col(cmd_col), .cmd_base(cmd_base), .cmd_imm(cmd_imm), .cmd_vd(cmd_vd),
    .cmd_sdata(cmd_sdata), .sp_req_valid(sp_req_valid), .sp_req_ready(sp_req_ready),
    .sp_wen(sp_wen), .sp_addr(sp_addr), .sp_wdata(sp_wdata), .sp_rvalid(sp_rvalid),
    .sp_rdata(sp_rdata), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_vd(wb_vd),
    .wb_data(wb_data), .st_done(st_done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Scratchpad contents: a fixed per-channel function of the address
  function automatic logic [DW-1:0] memWord(int c, logic [AW-1:0] a);
    return a ^ (16'h5A5A + 16'(c) * 16'h0101);
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkData(string name, logic [VW-1:0] act, logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one command onto channel c and push everything it should produce
  task automatic applyStimulus(int c, bit st, bit col, logic [AW-1:0] base,
                               logic [7:0] imm, logic [3:0] vd);
    logic [AW-1:0] eff, a;
    logic [VW-1:0] sd, ld;
    req_t r;
    wb_t  w;
    eff = base + {{(AW-8){imm[7]}}, imm};
    for (int i = 0; i < VLEN; i++) begin
      a = eff + AW'(i) * (col ? AW'(CS) : AW'(1));
      sd[i*DW +: DW] = 16'h1000 + 16'(i) + 16'(c) * 16'h0100;
      ld[i*DW +: DW] = memWord(c, a);
      r.wen   = st;
      r.addr  = a;
      r.wdata = sd[i*DW +: DW];
      r.last  = (i == VLEN - 1);
      exp_req[c].push_back(r);
    end
    if (st) st_pend[c]++;
    else begin
      w.vd = vd;
      w.data = ld;
      exp_wb[c].push_back(w);
      last_wb_exp[c] = ld;
    end
    cmd_valid[c] = 1'b1;
    cmd_store[c] = st;
    cmd_col[c]   = col;
    cmd_base[c*AW +: AW] = base;
    cmd_imm[c*8 +: 8]    = imm;
    cmd_vd[c*4 +: 4]     = vd;
    cmd_sdata[c*VW +: VW] = sd;
  endtask

  task automatic fireCmd();
    @(posedge CLK); #1;
    cmd_valid = '0;
  endtask

  task automatic waitCycles(int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // Cycle index of the first wb_valid/st_done, counting the accept cycle as 0
  task automatic measureLatency(int c, bit want_st, output int n);
    n = 1;
    while (!(want_st ? st_done[c] : wb_valid[c]) && n < 400) begin
      @(posedge CLK); #1;
      n++;
    end
  endtask

  task automatic waitAccepts(int c, int target);
    int k;
    k = 0;
    while (acc_cnt[c] < target && k < 400) begin @(posedge CLK); #1; k++; end
    checkOutput("accepts_reached", acc_cnt[c] >= target, 1);
  endtask

  task automatic waitWbEmpty(int c);
    int k;
    k = 0;
    while (exp_wb[c].size() > 0 && k < 400) begin @(posedge CLK); #1; k++; end
    checkOutput("wb_drained", exp_wb[c].size(), 0);
  endtask

  // Scratchpad response side: one response per cycle, in request order
  initial begin : sp_model
    sp_rvalid = '0;
    sp_rdata  = '0;
    forever begin
      @(posedge CLK); #2;
      for (int c = 0; c < NCH; c++) begin
        if (!nRST) begin
          pend[c].delete();
          sp_rvalid[c] = 1'b0;
        end else if (!hold[c] && pend[c].size() > 0) begin
          sp_rvalid[c] = 1'b1;
          sp_rdata[c*DW +: DW] = memWord(c, pend[c].pop_front());
        end else begin
          sp_rvalid[c] = 1'b0;
        end
      end
    end
  end

  // Monitor: compares requests, writebacks and store completions as they appear
  initial begin : monitor
    req_t e;
    wb_t  w;
    logic [AW-1:0] a;
    forever begin
      @(negedge CLK);
      cyc++;
      for (int c = 0; c < NCH; c++) begin
        if (!nRST) begin
          stall_prev[c] = 1'b0;
          continue;
        end
        a = sp_addr[c*AW +: AW];
        if (stall_prev[c]) begin
          checkOutput("req_hold_valid", sp_req_valid[c], 1);
          checkOutput("req_hold_addr", a, stall_addr[c]);
        end
        stall_prev[c] = sp_req_valid[c] && !sp_req_ready[c];
        stall_addr[c] = a;
        if (sp_rvalid[c] && outst_m[c] > 0) outst_m[c]--;
        if (sp_req_valid[c] && sp_req_ready[c]) begin
          acc_cnt[c]++;
          checkOutput("req_expected", exp_req[c].size() > 0, 1);
          if (exp_req[c].size() > 0) begin
            e = exp_req[c].pop_front();
            checkOutput("req_addr", a, e.addr);
            checkOutput("req_wen", sp_wen[c], e.wen);
            if (e.wen) begin
              checkOutput("req_wdata", sp_wdata[c*DW +: DW], e.wdata);
              if (e.last) last_st_acc[c] = cyc;
            end
          end
          if (!sp_wen[c]) begin
            pend[c].push_back(a);
            outst_m[c]++;
            if (outst_m[c] > max_outst) max_outst = outst_m[c];
          end
        end
        if (wb_valid[c] && wb_ready[c]) begin
          checkOutput("wb_expected", exp_wb[c].size() > 0, 1);
          if (exp_wb[c].size() > 0) begin
            w = exp_wb[c].pop_front();
            checkOutput("wb_vd", wb_vd[c*4 +: 4], w.vd);
            checkData("wb_data", wb_data[c*VW +: VW], w.data);
          end
        end
        if (st_done[c]) begin
          checkOutput("st_done_pending", st_pend[c] > 0, 1);
          if (st_pend[c] > 0) begin
            st_pend[c]--;
            checkOutput("st_done_timing", cyc, last_st_acc[c] + 1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    n_bad++;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin : main
    nRST = 1'b0;
    cmd_valid = '0; cmd_store = '0; cmd_col = '0; cmd_base = '0;
    cmd_imm = '0; cmd_vd = '0; cmd_sdata = '0;
    sp_req_ready = '0; wb_ready = '0;
    #3;
    checkOutput("rst_cmd_ready", cmd_ready, 2'b11);
    checkOutput("rst_req_valid", sp_req_valid, 0);
    checkOutput("rst_wen", sp_wen, 0);
    checkOutput("rst_addr", sp_addr, 0);
    checkOutput("rst_wb_valid", wb_valid, 0);
    checkOutput("rst_wb_data", |wb_data, 0);
    checkOutput("rst_st_done", st_done, 0);
    waitCycles(2);
    nRST = 1'b1;
    sp_req_ready = '1;
    wb_ready = '1;
    waitCycles(1);

    // Row load, base 0x0100 imm -4 -> addresses 0x00FC..0x011B
    applyStimulus(0, 1'b0, 1'b0, 16'h0100, 8'hFC, 4'd5);
    fireCmd();
    checkOutput("t1_cmd_ready_low", cmd_ready[0], 0);
    measureLatency(0, 1'b0, lat);
    checkOutput("t1_load_latency", lat, VLEN + 2);
    waitCycles(2);
    checkOutput("t1_cmd_ready_back", cmd_ready[0], 1);

    // Column store with address wrap: 0xFFE0, 0x0000, 0x0020, ...
    applyStimulus(1, 1'b1, 1'b1, 16'hFFE0, 8'h00, 4'd0);
    fireCmd();
    measureLatency(1, 1'b1, lat);
    checkOutput("t2_store_latency", lat, VLEN + 1);
    waitCycles(3);
    checkOutput("t2_st_done_seen", st_pend[1], 0);
    checkOutput("t2_cmd_ready_back", cmd_ready[1], 1);

    // Backpressure: ready low for 3 cycles mid-load
`ifdef VLS_PERF_CNT_EN
    p0 = perf_stall[31:0];
`endif
    a0 = acc_cnt[0];
    applyStimulus(0, 1'b0, 1'b0, 16'h0200, 8'h00, 4'd3);
    fireCmd();
    waitAccepts(0, a0 + 8);
    sp_req_ready[0] = 1'b0;
    waitCycles(3);
    sp_req_ready[0] = 1'b1;
    waitWbEmpty(0);
`ifdef VLS_PERF_CNT_EN
    checkOutput("t3_perf_stall", perf_stall[31:0] - p0, 3);
`endif

    // Delayed responses: issue must stop at the outstanding limit
    hold[0] = 1'b1;
    a0 = acc_cnt[0];
    applyStimulus(0, 1'b0, 1'b0, 16'h0300, 8'h10, 4'd7);
    fireCmd();
    waitCycles(10);
    checkOutput("t4_issue_capped", acc_cnt[0] - a0, MAXO);
    checkOutput("t4_req_blocked", sp_req_valid[0], 0);
    hold[0] = 1'b0;
    waitWbEmpty(0);

    // Parallel channels: ch0 load with held writeback, ch1 store with gappy ready
    wb_ready[0] = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 16'h0400, 8'h7F, 4'd9);
    applyStimulus(1, 1'b1, 1'b0, 16'h1000, 8'h80, 4'd0);
    fireCmd();
    fork
      measureLatency(0, 1'b0, lat0);
      begin
        for (int k = 0; k < 40; k++) begin
          sp_req_ready[1] = ((k % 3) != 0);
          @(posedge CLK); #1;
        end
        sp_req_ready[1] = 1'b1;
      end
    join
    checkOutput("t5_load_latency", lat0, VLEN + 2);
    for (int k = 0; k < 5; k++) begin
      checkOutput("t5_wb_valid_held", wb_valid[0], 1);
      checkOutput("t5_cmd_ready_low", cmd_ready[0], 0);
      checkOutput("t5_wb_vd_held", wb_vd[3:0], 4'd9);
      checkData("t5_wb_data_held", wb_data[VW-1:0], last_wb_exp[0]);
      waitCycles(1);
    end
    wb_ready[0] = 1'b1;
    waitCycles(1);
    checkOutput("t5_cmd_ready_after_wb", cmd_ready[0], 1);
    for (int k = 0; k < 100 && st_pend[1] > 0; k++) waitCycles(1);
    checkOutput("t5_store_done", st_pend[1], 0);

    // Reset mid-RUN at iss=10, then a fresh load
    a0 = acc_cnt[0];
    applyStimulus(0, 1'b0, 1'b0, 16'h0500, 8'h00, 4'd1);
    fireCmd();
    waitAccepts(0, a0 + 10);
    nRST = 1'b0;
    exp_req[0].delete();
    exp_wb[0].delete();
    pend[0].delete();
    outst_m[0] = 0;
    #1;
    checkOutput("t6_cmd_ready", cmd_ready, 2'b11);
    checkOutput("t6_req_valid", sp_req_valid, 0);
    checkOutput("t6_addr", sp_addr, 0);
    checkOutput("t6_wb_valid", wb_valid, 0);
    checkOutput("t6_st_done", st_done, 0);
    waitCycles(2);
    nRST = 1'b1;
    waitCycles(1);
    applyStimulus(0, 1'b0, 1'b0, 16'h0600, 8'h00, 4'd2);
    fireCmd();
    measureLatency(0, 1'b0, lat);
    checkOutput("t6_load_latency", lat, VLEN + 2);
    waitCycles(3);

    for (int c = 0; c < NCH; c++) begin
      checkOutput("end_req_queue", exp_req[c].size(), 0);
      checkOutput("end_wb_queue", exp_wb[c].size(), 0);
      checkOutput("end_st_pending", st_pend[c], 0);
    end
    checkOutput("outst_peak", max_outst, MAXO);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
